eq_stream_checker: RTL and testbench

- Downstream consumer of the equivalence-check top: observes the two output AXI-stream ports (ILA spec side and HLS RTL side), which emit identical pixel sequences at different cycle timings.
- Buffers each side in its own FIFO, compares beats strictly in order, and counts matches.
- Raises sticky mismatch/overflow flags and a done flag after NUM_BEATS equal beats; these flags drive the property-checker assertions.

---
 rtl/eq_stream_checker_if.sv | 23 ++
 rtl/eq_stream_checker.sv | 181 ++++++++++++++++++
 tb/tb_eq_stream_checker.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_stream_checker_if.sv
// Stream-side bundle seen by the checker: shared sink ready plus the ILA and HLS
// output streams, driven by the equivalence-check top (master) into the checker (slave).
`default_nettype none

interface eq_stream_checker_if #(
    parameter int DATA_W = 8
);
    logic              tready;
    logic [DATA_W-1:0] ila_tdata;
    logic              ila_tvalid;
    logic [DATA_W-1:0] hls_tdata;
    logic              hls_tvalid;

    modport master (
        output tready, ila_tdata, ila_tvalid, hls_tdata, hls_tvalid
    );

    modport slave (
        input  tready, ila_tdata, ila_tvalid, hls_tdata, hls_tvalid
    );
endinterface

`default_nettype wire

// File: rtl/eq_stream_checker.sv
// ============================================================================
// Module   : eq_stream_checker
// Purpose  : Buffers the ILA and HLS output streams in per-side FIFOs, compares
//            beats in order and raises sticky done/mismatch/overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eq_stream_checker #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 16,
    parameter int NUM_BEATS = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst_init,
    eq_stream_checker_if.slave              strm,
    output logic [CNT_W-1:0]                match_cnt,
    output logic                            mismatch,
    output logic [CNT_W-1:0]                mis_idx,
    output logic [DATA_W-1:0]               mis_ila,
    output logic [DATA_W-1:0]               mis_hls,
    output logic                            overflow,
    output logic                            ovf_side,
    output logic                            done,
    output logic [$clog2(DEPTH):0]          ila_level,
    output logic [$clog2(DEPTH):0]          hls_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0] c_FULL    = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] c_LVL_ONE = LVL_W'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_NUM     = CNT_W'(NUM_BEATS);

    localparam logic [1:0] ST_CHECK = 2'd0;
    localparam logic [1:0] ST_PASS  = 2'd1;
    localparam logic [1:0] ST_FAIL  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_checking;

    // Index 0 is the ILA side, index 1 the HLS side.
    logic [1:0]             w_vld;
    logic [1:0][DATA_W-1:0] w_din;
    logic [1:0][DATA_W-1:0] w_head;
    logic [1:0][LVL_W-1:0]  w_level;
    logic [1:0]             w_push_req;
    logic [1:0]             w_full;
    logic [1:0]             w_nempty;
    logic [1:0]             w_ovf;
    logic [1:0]             w_wr;
    logic                   w_pop;
    logic                   w_eq;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   w_hit;

    assign w_vld = {strm.hls_tvalid, strm.ila_tvalid};
    assign w_din = {strm.hls_tdata, strm.ila_tdata};

    // Heads pop together only when both sides hold data; no bypass path.
    assign w_pop     = w_checking & (&w_nempty);
    assign w_eq      = (w_head[0] == w_head[1]);
    assign w_cnt_inc = match_cnt + c_CNT_ONE;
    assign w_hit     = (w_cnt_inc == c_NUM);

    genvar gs;
    generate
        for (gs = 0; gs < 2; gs++) begin : g_fifo
            logic [DATA_W-1:0] r_mem [DEPTH];
            logic [PTR_W-1:0]  r_wptr;
            logic [PTR_W-1:0]  r_rptr;
            logic [LVL_W-1:0]  r_lvl;

            assign w_push_req[gs] = w_checking & w_vld[gs] & strm.tready;
            assign w_full[gs]     = (r_lvl == c_FULL);
            assign w_nempty[gs]   = (r_lvl != '0);
            // A full FIFO still accepts a beat if its head leaves on the same edge.
            assign w_ovf[gs]      = w_push_req[gs] & w_full[gs] & ~w_pop;
            assign w_wr[gs]       = w_push_req[gs] & ~w_ovf[gs];
            assign w_head[gs]     = r_mem[r_rptr];
            assign w_level[gs]    = r_lvl;

            always_ff @(posedge clk) begin
                if (w_wr[gs]) begin
                    r_mem[r_wptr] <= w_din[gs];
                end
            end

            always_ff @(posedge clk) begin
                if (rst_init) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_lvl  <= '0;
                end else begin
                    if (w_wr[gs]) begin
                        r_wptr <= r_wptr + c_PTR_ONE;
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + c_PTR_ONE;
                    end
                    if (w_wr[gs] && !w_pop) begin
                        r_lvl <= r_lvl + c_LVL_ONE;
                    end else if (!w_wr[gs] && w_pop) begin
                        r_lvl <= r_lvl - c_LVL_ONE;
                    end
                end
            end
        end
    endgenerate

    assign ila_level = w_level[0];
    assign hls_level = w_level[1];

    always_ff @(posedge clk) begin
        if (rst_init) begin
            r_state <= ST_CHECK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CHECK: begin
                if ((|w_ovf) || (w_pop && !w_eq)) begin
                    w_state_nxt = ST_FAIL;
                end else if (w_pop && w_hit) begin
                    w_state_nxt = ST_PASS;
                end
            end
            ST_PASS:  w_state_nxt = ST_PASS;
            ST_FAIL:  w_state_nxt = ST_FAIL;
            default:  w_state_nxt = ST_FAIL;
        endcase
    end

    always_comb begin
        w_checking = (r_state == ST_CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst_init) begin
            match_cnt <= '0;
            mismatch  <= 1'b0;
            mis_idx   <= '0;
            mis_ila   <= '0;
            mis_hls   <= '0;
            overflow  <= 1'b0;
            ovf_side  <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (w_pop) begin
                if (w_eq) begin
                    match_cnt <= w_cnt_inc;
                    if (w_hit) begin
                        done <= 1'b1;
                    end
                end else begin
                    mismatch <= 1'b1;
                    mis_idx  <= match_cnt;
                    mis_ila  <= w_head[0];
                    mis_hls  <= w_head[1];
                end
            end
            // ILA wins the side report when both overflow together.
            if (|w_ovf) begin
                overflow <= 1'b1;
                ovf_side <= ~w_ovf[0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eq_stream_checker.sv
// Directed bench for eq_stream_checker: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
`default_nettype none

module tb_eq_stream_checker;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 8;
    localparam int LVL_W  = 4;

    localparam int F_CNT  = 0;
    localparam int F_MIS  = 1;
    localparam int F_IDX  = 2;
    localparam int F_MILA = 3;
    localparam int F_MHLS = 4;
    localparam int F_OVF  = 5;
    localparam int F_SIDE = 6;
    localparam int F_DONE = 7;
    localparam int F_ILVL = 8;
    localparam int F_HLVL = 9;

    logic clk = 1'b0;
    logic rst_init;

    logic [CNT_W-1:0]  match_cnt;
    logic              mismatch;
    logic [CNT_W-1:0]  mis_idx;
    logic [DATA_W-1:0] mis_ila;
    logic [DATA_W-1:0] mis_hls;
    logic              overflow;
    logic              ovf_side;
    logic              done;
    logic [LVL_W-1:0]  ila_level;
    logic [LVL_W-1:0]  hls_level;

    eq_stream_checker_if #(.DATA_W(DATA_W)) sif ();

    eq_stream_checker #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .NUM_BEATS(16)
    ) dut (
        .clk       (clk),
        .rst_init  (rst_init),
        .strm      (sif),
        .match_cnt (match_cnt),
        .mismatch  (mismatch),
        .mis_idx   (mis_idx),
        .mis_ila   (mis_ila),
        .mis_hls   (mis_hls),
        .overflow  (overflow),
        .ovf_side  (ovf_side),
        .done      (done),
        .ila_level (ila_level),
        .hls_level (hls_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string name;
        int    field;
        int    val;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic integer get_field(input int f);
        case (f)
            F_CNT:   return integer'(match_cnt);
            F_MIS:   return integer'(mismatch);
            F_IDX:   return integer'(mis_idx);
            F_MILA:  return integer'(mis_ila);
            F_MHLS:  return integer'(mis_hls);
            F_OVF:   return integer'(overflow);
            F_SIDE:  return integer'(ovf_side);
            F_DONE:  return integer'(done);
            F_ILVL:  return integer'(ila_level);
            default: return integer'(hls_level);
        endcase
    endfunction

    // Monitor: compares every expectation queued during the current cycle.
    always @(negedge clk) begin
        exp_t   e;
        integer got;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            got = get_field(e.field);
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, got, e.val, cyc);
            end
        end
    end

    task automatic ex(input string n, input int f, input int v);
        q.push_back('{cyc, n, f, v});
    endtask

    task automatic ex_zero(input string n);
        for (int f = F_CNT; f <= F_HLVL; f++) begin
            ex($sformatf("%s.f%0d", n, f), f, 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input int id, input bit hv, input int hd);
        sif.ila_tvalid = iv;
        sif.ila_tdata  = DATA_W'(id);
        sif.hls_tvalid = hv;
        sif.hls_tdata  = DATA_W'(hd);
    endtask

    task automatic do_reset(input string n);
        rst_init   = 1'b1;
        sif.tready = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        rst_init = 1'b0;
        ex_zero(n);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_init   = 1'b1;
        sif.tready = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        tick();

        // Lockstep equal stream 0x01..0x10.
        do_reset("rst_lock");
        for (int i = 1; i <= 16; i++) begin
            drive(1, i, 1, i);
            tick();
            if (i == 1) begin
                ex("lock_cnt1", F_CNT, 0);
                ex("lock_ilvl1", F_ILVL, 1);
                ex("lock_hlvl1", F_HLVL, 1);
            end
            if (i == 16) begin
                ex("lock_cnt16", F_CNT, 15);
                ex("lock_done_early", F_DONE, 0);
            end
        end
        drive(0, 0, 0, 0);
        tick();
        ex("lock_cnt", F_CNT, 16);
        ex("lock_done", F_DONE, 1);
        ex("lock_mis", F_MIS, 0);
        ex("lock_ovf", F_OVF, 0);
        ex("lock_ilvl", F_ILVL, 0);
        drive(1, 8'h55, 1, 8'h55);
        tick();
        ex("pass_frozen_ilvl", F_ILVL, 0);
        ex("pass_frozen_cnt", F_CNT, 16);

        // Skewed latency: HLS trails ILA by three cycles.
        do_reset("rst_skew");
        for (int c = 1; c <= 8; c++) begin
            drive(c <= 5, c, c >= 4, c - 3);
            tick();
            if (c == 3) begin
                ex("skew_ilvl3", F_ILVL, 3);
                ex("skew_hlvl3", F_HLVL, 0);
            end
            if (c == 8) ex("skew_cnt8", F_CNT, 4);
        end
        drive(0, 0, 0, 0);
        tick();
        ex("skew_cnt", F_CNT, 5);
        ex("skew_ilvl", F_ILVL, 0);
        ex("skew_mis", F_MIS, 0);
        ex("skew_ovf", F_OVF, 0);

        // Mismatch at beat index 3.
        do_reset("rst_mis");
        drive(1, 1, 1, 1);         tick();
        drive(1, 2, 1, 2);         tick();
        drive(1, 3, 1, 3);         tick();
        drive(1, 8'h7F, 1, 8'h80); tick();
        drive(0, 0, 0, 0);         tick();
        ex("mis_flag", F_MIS, 1);
        ex("mis_idx", F_IDX, 3);
        ex("mis_ila", F_MILA, 8'h7F);
        ex("mis_hls", F_MHLS, 8'h80);
        ex("mis_cnt", F_CNT, 3);
        ex("mis_done", F_DONE, 0);
        drive(1, 9, 1, 10); tick();
        drive(1, 11, 1, 12); tick();
        ex("fail_frozen_ilvl", F_ILVL, 0);
        ex("fail_frozen_cnt", F_CNT, 3);
        ex("fail_frozen_mila", F_MILA, 8'h7F);
        ex("fail_frozen_idx", F_IDX, 3);

        // ILA overflow: 9 beats into an 8-deep FIFO.
        do_reset("rst_ovf");
        for (int i = 1; i <= 9; i++) begin
            drive(1, 8'h10 + i, 0, 0);
            tick();
            if (i == 8) begin
                ex("ovf_ilvl8", F_ILVL, 8);
                ex("ovf_early", F_OVF, 0);
            end
        end
        ex("ovf_flag", F_OVF, 1);
        ex("ovf_side", F_SIDE, 0);
        ex("ovf_ilvl", F_ILVL, 8);
        drive(0, 0, 1, 8'h11);
        tick();
        ex("ovf_frozen_hlvl", F_HLVL, 0);

        // HLS overflow reports side 1.
        do_reset("rst_hovf");
        for (int i = 1; i <= 9; i++) begin
            drive(0, 0, 1, i);
            tick();
        end
        ex("hovf_flag", F_OVF, 1);
        ex("hovf_side", F_SIDE, 1);
        ex("hovf_hlvl", F_HLVL, 8);
        ex("hovf_ilvl", F_ILVL, 0);

        // Full ILA FIFO accepts a 9th beat because the heads pop that edge.
        do_reset("rst_full");
        for (int i = 1; i <= 8; i++) begin
            drive(1, 8'h20 + i, i == 8, 8'h21);
            tick();
        end
        ex("full_ilvl8", F_ILVL, 8);
        ex("full_hlvl8", F_HLVL, 1);
        drive(1, 8'h29, 0, 0);
        tick();
        ex("full_ovf", F_OVF, 0);
        ex("full_ilvl", F_ILVL, 8);
        ex("full_hlvl", F_HLVL, 0);
        ex("full_cnt", F_CNT, 1);
        ex("full_mis", F_MIS, 0);

        // tready gating, then reset mid-stream.
        do_reset("rst_trdy");
        sif.tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1);
            tick();
        end
        ex("trdy_ilvl", F_ILVL, 0);
        ex("trdy_hlvl", F_HLVL, 0);
        sif.tready = 1'b1;
        drive(1, 1, 0, 0); tick();
        drive(1, 2, 0, 0); tick();
        drive(1, 3, 1, 1); tick();
        ex("mid_ilvl", F_ILVL, 3);
        ex("mid_hlvl", F_HLVL, 1);
        rst_init = 1'b1;
        tick();
        ex_zero("mid_rst");
        rst_init = 1'b0;
        drive(1, 4, 1, 4);
        tick();
        ex("resume_ilvl", F_ILVL, 1);
        ex("resume_hlvl", F_HLVL, 1);
        drive(0, 0, 0, 0);
        tick();
        ex("resume_cnt", F_CNT, 1);

        tick();
        tick();
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
            errors += q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
